// File: rtl/fft_stage_sequencer.sv
// Stage/index sequencer feeding index_mapper: sweeps 0..2^N_LOG2-1 once per stage with valid/ready flow control.
// Optional macro STAGE_GAP_EN inserts GAP_CYCLES idle bubbles between stages.
module fft_stage_sequencer #(
    parameter int N_LOG2     = 4,
    parameter int STAGE_W    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               ready,
    output logic               valid,
    output logic [N_LOG2-1:0]  index_out,
    output logic [STAGE_W-1:0] stage_out,
    output logic               first_of_stage,
    output logic               last_of_stage,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [N_LOG2-1:0]  INDEX_LAST = {N_LOG2{1'b1}};
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_LOG2 - 1);

    state_t               r_state, w_state_nxt;
    logic [N_LOG2-1:0]    r_index, w_index_nxt;
    logic [STAGE_W-1:0]   r_stage, w_stage_nxt;

`ifdef STAGE_GAP_EN
    localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    logic [GAP_W-1:0] r_gap_cnt, w_gap_nxt;
`else
    // The bubble length only matters when the gap state is compiled in.
    logic w_unused_gap;
    assign w_unused_gap = (GAP_CYCLES != 0);
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_stage_nxt = r_stage;
`ifdef STAGE_GAP_EN
        w_gap_nxt   = r_gap_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_index_nxt = '0;
                    w_stage_nxt = '0;
                end
            end
            S_RUN: begin
                // valid is always high in RUN, so ready alone decides the transfer.
                if (ready) begin
                    if (r_index == INDEX_LAST) begin
                        w_index_nxt = '0;
                        if (r_stage == STAGE_LAST) begin
                            w_state_nxt = S_DONE;
                            w_stage_nxt = '0;
                        end else begin
                            w_stage_nxt = r_stage + 1'b1;
`ifdef STAGE_GAP_EN
                            if (GAP_CYCLES > 0) begin
                                w_state_nxt = S_GAP;
                                w_gap_nxt   = '0;
                            end
`endif
                        end
                    end else begin
                        w_index_nxt = r_index + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_index_nxt = '0;
                w_stage_nxt = '0;
            end
`ifdef STAGE_GAP_EN
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_stage <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_stage <= w_stage_nxt;
        end
    end

`ifdef STAGE_GAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= w_gap_nxt;
        end
    end
`endif

    assign valid          = (r_state == S_RUN);
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign index_out      = r_index;
    assign stage_out      = r_stage;
    assign first_of_stage = valid && (r_index == '0);
    assign last_of_stage  = valid && (r_index == INDEX_LAST);

endmodule
